// File: rtl/arp_reply_gen_if.sv
// arp_reply_gen_if
//   Bundles the ARP receiver feed, the transmit-arbiter handshake and the
//   reply byte stream of arp_reply_gen.
//   arp_bus   : [10]=crc_ok, [9]=reply strobe, [8]=write, [7:0]=captured byte
//   tx_req    : reply pending, asking for a transmit slot
//   tx_ack    : one-cycle grant from the transmit arbiter
//   tx_data   : reply byte, zero while tx_strobe is low
//   tx_strobe : tx_data valid, contiguous for the whole packet
//   drop_cnt  : saturating count of valid requests dropped while busy
//   Modports: master = receiver/arbiter side, slave = arp_reply_gen.
interface arp_reply_gen_if;
  logic [10:0] arp_bus;
  logic        tx_req;
  logic        tx_ack;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic [7:0]  drop_cnt;

  modport master (
    output arp_bus, tx_ack,
    input  tx_req, tx_data, tx_strobe, drop_cnt
  );

  modport slave (
    input  arp_bus, tx_ack,
    output tx_req, tx_data, tx_strobe, drop_cnt
  );
endinterface

// File: rtl/arp_reply_gen.sv
// arp_reply_gen
//   Captures the requester MAC/IP from the ARP receiver and, on a valid
//   reply strobe, emits a complete ARP reply packet once the transmit
//   arbiter grants a slot.
//   Parameters: ip  - our IPv4 address (reply sender IP)
//               mac - our MAC (reply source MAC and sender MAC)
//   Ports: clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          bus   - arp_reply_gen_if.slave (arp_bus, tx_ack in;
//                  tx_req, tx_data, tx_strobe, drop_cnt out)
//   Build option: define ARP_REPLY_PAD_EN to append 18 zero bytes so the
//   packet is 60 bytes; otherwise the packet ends after 42 bytes.
module arp_reply_gen #(
  parameter logic [31:0] ip  = 32'hC0A80702,
  parameter logic [47:0] mac = 48'h125555000131
) (
  input  logic            clk,
  input  logic            rst_n,
  arp_reply_gen_if.slave  bus
);

`ifdef ARP_REPLY_PAD_EN
  localparam int FRAME_LEN = 60;
`else
  localparam int FRAME_LEN = 42;
`endif
  localparam logic [5:0]  LAST_BYTE = 6'(FRAME_LEN - 1);
  // Fixed ARP header: htype, ptype, hlen, plen, opcode (reply)
  localparam logic [79:0] ARP_HDR   = 80'h0806_0001_0800_0604_0002;

  typedef enum logic [1:0] {IDLE, PEND, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wi_q, wi_d;
  logic [5:0]  byteCnt_q, byteCnt_d;
  logic [7:0]  dropCnt_q, dropCnt_d;
  logic [7:0]  capBuf_q [10];
  logic [7:0]  txBuf_q  [10];
  logic [7:0]  frame    [FRAME_LEN];
  logic        crcOk, replyStb, wrEn, accept, loadTx, capWrite;
  logic [7:0]  wrByte;

  assign crcOk    = bus.arp_bus[10];
  assign replyStb = bus.arp_bus[9];
  assign wrEn     = bus.arp_bus[8];
  assign wrByte   = bus.arp_bus[7:0];
  assign capWrite = wrEn && (wi_q != 4'd10);
  assign accept   = replyStb && crcOk && (wi_q == 4'd10);

  // The strobe always rewinds the capture index, even if a write coincides.
  always_comb begin
    wi_d = wi_q;
    if (replyStb) begin
      wi_d = 4'd0;
    end else if (capWrite) begin
      wi_d = wi_q + 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    dropCnt_d = dropCnt_q;
    loadTx    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          loadTx  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (bus.tx_ack) begin
          state_d   = SEND;
          byteCnt_d = 6'd0;
        end
      end
      SEND: begin
        if (byteCnt_q == LAST_BYTE) begin
          state_d = IDLE;
        end else begin
          byteCnt_d = byteCnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request accepted on the final SEND cycle still sees state SEND and
    // is therefore counted as dropped.
    if (accept && (state_q != IDLE) && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wi_q      <= 4'd0;
      byteCnt_q <= 6'd0;
      dropCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      wi_q      <= wi_d;
      byteCnt_q <= byteCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // Buffers carry no reset: transmit contents only become visible after a
  // fresh accepted request has overwritten them.
  always_ff @(posedge clk) begin
    if (capWrite) begin
      capBuf_q[wi_q] <= wrByte;
    end
    if (loadTx) begin
      txBuf_q <= capBuf_q;
    end
  end

  // Assemble the reply image; multi-byte fields go out MSB first.
  always_comb begin
    for (int k = 0; k < FRAME_LEN; k++) begin
      frame[k] = 8'h00;
    end
    for (int k = 0; k < 6; k++) begin
      frame[k]      = txBuf_q[k];
      frame[6 + k]  = 8'(mac >> (8 * (5 - k)));
      frame[22 + k] = 8'(mac >> (8 * (5 - k)));
      frame[32 + k] = txBuf_q[k];
    end
    for (int k = 0; k < 10; k++) begin
      frame[12 + k] = 8'(ARP_HDR >> (8 * (9 - k)));
    end
    for (int k = 0; k < 4; k++) begin
      frame[28 + k] = 8'(ip >> (8 * (3 - k)));
      frame[38 + k] = txBuf_q[6 + k];
    end
  end

  assign bus.tx_req    = (state_q == PEND);
  assign bus.tx_strobe = (state_q == SEND);
  assign bus.tx_data   = (state_q == SEND) ? frame[byteCnt_q] : 8'h00;
  assign bus.drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_arp_reply_gen.sv
// tb_arp_reply_gen
//   Directed bench for arp_reply_gen: reset state, request filtering,
//   reply packet contents, drop counting, back-to-back timing, reset in the
//   middle of a packet and drop counter saturation.
module tb_arp_reply_gen;

  localparam logic [31:0] OUR_IP  = 32'hC0A80702;
  localparam logic [47:0] OUR_MAC = 48'h125555000131;
`ifdef ARP_REPLY_PAD_EN
  localparam int EXP_LEN = 60;
`else
  localparam int EXP_LEN = 42;
`endif
  localparam logic [47:0] MAC1 = 48'h021122334455;
  localparam logic [31:0] IP1  = 32'hC0A80709;
  localparam logic [47:0] MAC2 = 48'hAABBCCDDEEFF;
  localparam logic [31:0] IP2  = 32'h0A000001;

  // Hand-assembled 42-byte replies for the two requesters
  localparam logic [335:0] EXP1 = 336'h021122334455_125555000131_08060001080006040002_125555000131_C0A80702_021122334455_C0A80709;
  localparam logic [335:0] EXP2 = 336'hAABBCCDDEEFF_125555000131_08060001080006040002_125555000131_C0A80702_AABBCCDDEEFF_0A000001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arp_reply_gen_if ifc ();

  arp_reply_gen #(.ip(OUR_IP), .mac(OUR_MAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nBad    = 0;
  logic [7:0]  rx [0:127];
  int          rxLen;
  logic [10:0] busQ [$];

  task automatic checkOutput(input string tag, input logic [47:0] act, input logic [47:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, changed on the falling edge
  task automatic applyStimulus(input logic [10:0] busVal, input logic ack);
    @(negedge clk);
    ifc.arp_bus = busVal;
    ifc.tx_ack  = ack;
  endtask

  function automatic logic [7:0] reqByte(input logic [47:0] m, input logic [31:0] a, input int k);
    if (k < 6)       return 8'(m >> (8 * (5 - k)));
    else if (k < 10) return 8'(a >> (8 * (9 - k)));
    else             return 8'h5A;
  endfunction

  task automatic writeRequest(input logic [47:0] m, input logic [31:0] a, input int n, input logic ok);
    for (int k = 0; k < n; k++) begin
      applyStimulus({3'b001, reqByte(m, a, k)}, 1'b0);
    end
    applyStimulus({ok, 2'b10, 8'h00}, 1'b0);
  endtask

  task automatic queueRequest(input logic [47:0] m, input logic [31:0] a, input int lead, input logic withStrobe);
    busQ.delete();
    for (int k = 0; k < lead; k++) busQ.push_back(11'h000);
    for (int k = 0; k < 10; k++) busQ.push_back({3'b001, reqByte(m, a, k)});
    if (withStrobe) busQ.push_back(11'h600);
  endtask

  // Grant the slot, then land on the first byte of the packet
  task automatic ackAndStart(input string tag);
    applyStimulus(11'h000, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput({tag, "_req_low"}, ifc.tx_req, 0);
    checkOutput({tag, "_strobe_high"}, ifc.tx_strobe, 1);
  endtask

  // Record bytes while tx_strobe is high, feeding busQ one entry per cycle.
  task automatic collectPacket(input int resetAt);
    int guard;
    logic [10:0] nxt;
    rxLen = 0;
    guard = 0;
    while (ifc.tx_strobe && guard < 100) begin
      if (rxLen == resetAt) begin
        ifc.arp_bus = 11'h000;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_strobe", ifc.tx_strobe, 0);
        checkOutput("rst_data", ifc.tx_data, 0);
        checkOutput("rst_req", ifc.tx_req, 0);
        checkOutput("rst_drop", ifc.drop_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busQ.delete();
        return;
      end
      rx[rxLen] = ifc.tx_data;
      rxLen++;
      nxt = 11'h000;
      if (busQ.size() > 0) nxt = busQ.pop_front();
      ifc.arp_bus = nxt;
      ifc.tx_ack  = 1'b0;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("collect_timeout", 1, 0);
    ifc.arp_bus = 11'h000;
    busQ.delete();
  endtask

  task automatic comparePacket(input string tag, input logic [335:0] exp, input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      e = (k < 42) ? 8'(exp >> (8 * (41 - k))) : 8'h00;
      checkOutput($sformatf("%s_b%0d", tag, k), rx[k], e);
    end
  endtask

  initial begin
    ifc.arp_bus = 11'h000;
    ifc.tx_ack  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req", ifc.tx_req, 0);
    checkOutput("reset_strobe", ifc.tx_strobe, 0);
    checkOutput("reset_data", ifc.tx_data, 0);
    checkOutput("reset_drop", ifc.drop_cnt, 0);
    rst_n = 1'b1;

    // Bad CRC is discarded; a stray ack in IDLE starts nothing
    writeRequest(MAC1, IP1, 10, 1'b0);
    applyStimulus(11'h000, 1'b0);
    checkOutput("badcrc_req", ifc.tx_req, 0);
    checkOutput("badcrc_drop", ifc.drop_cnt, 0);
    applyStimulus(11'h000, 1'b1);
    applyStimulus(11'h000, 1'b0);
    applyStimulus(11'h000, 1'b0);
    checkOutput("stray_ack_strobe", ifc.tx_strobe, 0);
    checkOutput("stray_ack_req", ifc.tx_req, 0);

    // Short capture is discarded
    writeRequest(MAC1, IP1, 7, 1'b1);
    applyStimulus(11'h000, 1'b0);
    applyStimulus(11'h000, 1'b0);
    checkOutput("short_req", ifc.tx_req, 0);

    // Main reply, ack three cycles after the strobe
    writeRequest(MAC1, IP1, 10, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput("main_req_next", ifc.tx_req, 1);
    checkOutput("main_no_strobe", ifc.tx_strobe, 0);
    applyStimulus(11'h000, 1'b0);
    checkOutput("main_req_hold", ifc.tx_req, 1);
    ackAndStart("main");
    collectPacket(-1);
    checkOutput("main_len", rxLen, EXP_LEN);
    comparePacket("main", EXP1, EXP_LEN);
    checkOutput("main_end_data", ifc.tx_data, 0);
    checkOutput("main_end_req", ifc.tx_req, 0);

    // Second request during SEND is dropped, packet unaffected
    writeRequest(MAC1, IP1, 10, 1'b1);
    ackAndStart("busy");
    queueRequest(MAC2, IP2, 0, 1'b1);
    collectPacket(-1);
    checkOutput("busy_len", rxLen, EXP_LEN);
    comparePacket("busy", EXP1, EXP_LEN);
    checkOutput("busy_drop", ifc.drop_cnt, 1);
    applyStimulus(11'h000, 1'b0);
    applyStimulus(11'h000, 1'b0);
    checkOutput("busy_no_req", ifc.tx_req, 0);

    // Strobe on the last SEND cycle is dropped
    writeRequest(MAC1, IP1, 10, 1'b1);
    ackAndStart("b2b_drop");
    queueRequest(MAC2, IP2, EXP_LEN - 11, 1'b1);
    collectPacket(-1);
    checkOutput("b2b_drop_len", rxLen, EXP_LEN);
    applyStimulus(11'h000, 1'b0);
    checkOutput("b2b_drop_cnt", ifc.drop_cnt, 2);
    checkOutput("b2b_drop_req", ifc.tx_req, 0);

    // Strobe on the first IDLE cycle is accepted
    writeRequest(MAC1, IP1, 10, 1'b1);
    ackAndStart("b2b_acc");
    queueRequest(MAC2, IP2, EXP_LEN - 11, 1'b0);
    collectPacket(-1);
    ifc.arp_bus = 11'h600;
    applyStimulus(11'h000, 1'b0);
    checkOutput("b2b_acc_req", ifc.tx_req, 1);
    checkOutput("b2b_acc_drop", ifc.drop_cnt, 2);
    ackAndStart("second");
    collectPacket(-1);
    checkOutput("second_len", rxLen, EXP_LEN);
    comparePacket("second", EXP2, EXP_LEN);

    // Over-long capture saturates; reset at byte 20 truncates the packet
    writeRequest(MAC1, IP1, 12, 1'b1);
    ackAndStart("trunc");
    collectPacket(20);
    checkOutput("trunc_len", rxLen, 20);
    comparePacket("trunc", EXP1, 20);
    repeat (4) applyStimulus(11'h000, 1'b0);
    checkOutput("trunc_after_req", ifc.tx_req, 0);
    checkOutput("trunc_after_strobe", ifc.tx_strobe, 0);

    // Stray ack, then drop counter saturation while busy
    applyStimulus(11'h000, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput("sat_stray_strobe", ifc.tx_strobe, 0);
    writeRequest(MAC1, IP1, 10, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput("sat_req", ifc.tx_req, 1);
    for (int r = 0; r < 254; r++) writeRequest(MAC2, IP2, 10, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput("sat_254", ifc.drop_cnt, 254);
    for (int r = 0; r < 46; r++) writeRequest(MAC2, IP2, 10, 1'b1);
    applyStimulus(11'h000, 1'b0);
    checkOutput("sat_255", ifc.drop_cnt, 255);
    ackAndStart("sat");
    collectPacket(-1);
    checkOutput("sat_len", rxLen, EXP_LEN);
    comparePacket("sat", EXP1, EXP_LEN);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
